// File: rtl/keypad_digit_entry.sv
// 4x4 active-low matrix keypad scanner with full-scan debouncing.
// Emits a single-cycle DIGIT_VALID / CLEAR_PULSE / ENTER_PULSE per accepted press.
module keypad_digit_entry #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 10
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic [3:0] KEY_COL,
    output logic [3:0] KEY_ROW,
    output logic [3:0] DIGIT_OUT,
    output logic       DIGIT_VALID,
    output logic       CLEAR_PULSE,
    output logic       ENTER_PULSE,
    output logic       KEY_HELD
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_SCANS);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StPressDeb,
        StPressed,
        StRelDeb
    } state_t;

    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [DivW-1:0] r_div;
    logic [1:0]      r_row;
    logic [1:0]      r_acc_cnt;   // keys seen so far this scan: 0, 1, or 2 meaning "two or more"
    logic [3:0]      r_acc_code;  // {row, col} of the first key seen this scan
    state_t          r_state;
    logic [CntW-1:0] r_cnt;
    logic [3:0]      r_cand;      // only meaningful outside StIdle, so no separate NONE flag
    logic [3:0]      r_digit;
    logic            r_digit_valid;
    logic            r_clear;
    logic            r_enter;

    logic            w_tick;
    logic [2:0]      w_row_hits;
    logic [1:0]      w_row_col;
    logic [2:0]      w_acc_sum;
    logic [1:0]      w_acc_next;
    logic [3:0]      w_code_next;
    logic            w_scan_done;
    logic            w_scan_key;
    logic [CntW-1:0] w_cnt_inc;
    state_t          w_state_next;
    logic [CntW-1:0] w_cnt_next;
    logic [3:0]      w_cand_next;
    logic            w_accept;
    logic            w_is_digit;
    logic            w_is_clear;
    logic            w_is_enter;
    logic [3:0]      w_digit;

    // Two-flop synchroniser for the asynchronous column inputs.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
        end else begin
            r_sync1 <= KEY_COL;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick      = (r_div == DivLast);
    assign w_scan_done = w_tick && (r_row == 2'd3);

    // Row-slot divider; the row advances on the same edge that samples its columns.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_div <= '0;
            r_row <= 2'd0;
        end else if (w_tick) begin
            r_div <= '0;
            r_row <= r_row + 2'd1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Drive exactly one row low.
    always_comb begin
        KEY_ROW = ~(4'b0001 << r_row);
    end

    // Count pressed columns in the current row and locate the lowest one.
    always_comb begin
        w_row_hits = 3'd0;
        w_row_col  = 2'd0;
        for (int c = 0; c < 4; c++) begin
            if (!r_sync2[c]) begin
                w_row_hits = w_row_hits + 3'd1;
                if (w_row_hits == 3'd1) begin
                    w_row_col = 2'(c);
                end
            end
        end
    end

    // Merge this row's sample into the running scan result (saturating at "multi").
    always_comb begin
        w_acc_sum   = {1'b0, r_acc_cnt} + w_row_hits;
        w_acc_next  = (w_acc_sum >= 3'd2) ? 2'd2 : w_acc_sum[1:0];
        w_code_next = ((w_row_hits == 3'd1) && (r_acc_cnt == 2'd0)) ? {r_row, w_row_col}
                                                                      : r_acc_code;
        w_scan_key  = w_scan_done && (w_acc_next == 2'd1);
    end

    // Scan accumulator, cleared after each row-3 sample so the next scan starts fresh.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_acc_cnt  <= 2'd0;
            r_acc_code <= 4'd0;
        end else if (w_tick) begin
            if (r_row == 2'd3) begin
                r_acc_cnt  <= 2'd0;
                r_acc_code <= 4'd0;
            end else begin
                r_acc_cnt  <= w_acc_next;
                r_acc_code <= w_code_next;
            end
        end
    end

    // Decode the key at {row, col} into its action.
    always_comb begin
        w_is_digit = 1'b0;
        w_is_clear = 1'b0;
        w_is_enter = 1'b0;
        w_digit    = 4'd0;
        case (w_code_next)
            4'd0:  begin w_is_digit = 1'b1; w_digit = 4'd1; end
            4'd1:  begin w_is_digit = 1'b1; w_digit = 4'd2; end
            4'd2:  begin w_is_digit = 1'b1; w_digit = 4'd3; end
            4'd4:  begin w_is_digit = 1'b1; w_digit = 4'd4; end
            4'd5:  begin w_is_digit = 1'b1; w_digit = 4'd5; end
            4'd6:  begin w_is_digit = 1'b1; w_digit = 4'd6; end
            4'd8:  begin w_is_digit = 1'b1; w_digit = 4'd7; end
            4'd9:  begin w_is_digit = 1'b1; w_digit = 4'd8; end
            4'd10: begin w_is_digit = 1'b1; w_digit = 4'd9; end
            4'd13: begin w_is_digit = 1'b1; w_digit = 4'd0; end
            4'd12: w_is_clear = 1'b1;
            4'd14: w_is_enter = 1'b1;
            default: ;  // A-D: accepted but silent
        endcase
    end

    assign w_cnt_inc = (r_cnt == CntMax) ? CntMax : r_cnt + 1'b1;

    // Debounce FSM next-state, evaluated once per completed scan.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cand_next  = r_cand;
        w_accept     = 1'b0;
        if (w_scan_done) begin
            case (r_state)
                StIdle: begin
                    if (w_scan_key) begin
                        w_cand_next = w_code_next;
                        w_cnt_next  = CntOne;
                        if (CntOne == CntMax) begin
                            w_accept     = 1'b1;
                            w_state_next = StPressed;
                        end else begin
                            w_state_next = StPressDeb;
                        end
                    end
                end
                StPressDeb: begin
                    if (!w_scan_key) begin
                        w_cnt_next   = '0;
                        w_state_next = StIdle;
                    end else if (w_code_next == r_cand) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == CntMax) begin
                            w_accept     = 1'b1;
                            w_state_next = StPressed;
                        end
                    end else begin
                        w_cand_next = w_code_next;
                        w_cnt_next  = CntOne;
                    end
                end
                StPressed: begin
                    if (!w_scan_key) begin
                        w_cnt_next   = CntOne;
                        w_state_next = (CntOne == CntMax) ? StIdle : StRelDeb;
                    end
                end
                StRelDeb: begin
                    if (w_scan_key) begin
                        w_state_next = StPressed;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == CntMax) begin
                            w_state_next = StIdle;
                        end
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end
    end

    // Debounce FSM state register.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_cand  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_cand  <= w_cand_next;
        end
    end

    // Registered accept action: one-cycle pulses and the held digit.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_digit       <= 4'd12;
            r_digit_valid <= 1'b0;
            r_clear       <= 1'b0;
            r_enter       <= 1'b0;
        end else begin
            r_digit_valid <= w_accept && w_is_digit;
            r_clear       <= w_accept && w_is_clear;
            r_enter       <= w_accept && w_is_enter;
            if (w_accept && w_is_digit) begin
                r_digit <= w_digit;
            end
        end
    end

    assign DIGIT_OUT   = r_digit;
    assign DIGIT_VALID = r_digit_valid;
    assign CLEAR_PULSE = r_clear;
    assign ENTER_PULSE = r_enter;
    assign KEY_HELD    = (r_state == StPressed) || (r_state == StRelDeb);

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Bench for keypad_digit_entry: keypad model, scan-level reference model and pulse scoreboard.
module tb_keypad_digit_entry;

    localparam int SCAN_DIV  = 4;
    localparam int DEB       = 3;
    localparam int SCAN_CLKS = 4 * SCAN_DIV;

    // Key index = row*4 + col.
    localparam int K1 = 0, K3 = 2, KA = 3, K5 = 5, K8 = 9, K9 = 10, KSTAR = 12, K0 = 13;
    localparam int KHASH = 14;

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [3:0]  KEY_COL;
    logic [3:0]  KEY_ROW;
    logic [3:0]  DIGIT_OUT;
    logic        DIGIT_VALID;
    logic        CLEAR_PULSE;
    logic        ENTER_PULSE;
    logic        KEY_HELD;
    logic [15:0] keys = 16'h0;

    typedef struct {
        int kind;   // 0 digit, 1 clear, 2 enter
        int digit;  // DIGIT_OUT expected while the pulse is high
        int cyc;
    } ev_t;

    ev_t   sb[$];
    int    hist[$];
    string keymap = "123A456B789C*0#D";
    int    n_checks = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    base = 0;
    bit    mon_en = 1'b0;
    bit    m_held = 1'b0;
    int    m_digit = 12;

    keypad_digit_entry #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .KEY_COL    (KEY_COL),
        .KEY_ROW    (KEY_ROW),
        .DIGIT_OUT  (DIGIT_OUT),
        .DIGIT_VALID(DIGIT_VALID),
        .CLEAR_PULSE(CLEAR_PULSE),
        .ENTER_PULSE(ENTER_PULSE),
        .KEY_HELD   (KEY_HELD)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    // Physical keypad: a held key pulls its column low while its row is driven low.
    always_comb begin
        KEY_COL = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!KEY_ROW[r]) begin
                for (int c = 0; c < 4; c++) begin
                    if (keys[r*4+c]) KEY_COL[c] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -1 no key, -2 two or more keys, else the key index.
    function automatic int scan_result(input logic [15:0] m);
        int n = 0;
        int idx = -1;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                n++;
                idx = i;
            end
        end
        if (n == 0) return -1;
        if (n > 1) return -2;
        return idx;
    endfunction

    // Reference: a press is accepted once the last DEB scans all show the same single key while
    // nothing is held; a held key is released once the last DEB scans all show no single key.
    task automatic model_step(input logic [15:0] m, input int start_cyc);
        int  r;
        bit  all_same;
        bit  all_none;
        byte ch;
        ev_t ev;
        r = scan_result(m);
        hist.push_back(r);
        if (hist.size() > DEB) hist.delete(0);
        all_same = (hist.size() == DEB) && (r >= 0);
        all_none = (hist.size() == DEB);
        for (int i = 0; i < hist.size(); i++) begin
            if (hist[i] != r) all_same = 1'b0;
            if (hist[i] >= 0) all_none = 1'b0;
        end
        if (!m_held && all_same) begin
            m_held = 1'b1;
            ch = keymap[r];
            ev.cyc = start_cyc + SCAN_CLKS;
            if (ch >= "0" && ch <= "9") begin
                m_digit  = int'(ch) - 48;
                ev.kind  = 0;
                ev.digit = m_digit;
                sb.push_back(ev);
            end else if (ch == "*") begin
                ev.kind  = 1;
                ev.digit = m_digit;
                sb.push_back(ev);
            end else if (ch == "#") begin
                ev.kind  = 2;
                ev.digit = m_digit;
                sb.push_back(ev);
            end
        end else if (m_held && all_none) begin
            m_held = 1'b0;
        end
    endtask

    // One full scan with a fixed set of held keys, starting just after a scan boundary.
    task automatic do_scan(input logic [15:0] m);
        check("key_held", int'(KEY_HELD), int'(m_held));
        check("digit_out_hold", int'(DIGIT_OUT), m_digit);
        keys = m;
        model_step(m, cyc);
        repeat (SCAN_CLKS) @(negedge CLOCK);
    endtask

    task automatic do_scans(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) do_scan(m);
    endtask

    task automatic apply_reset(input logic [15:0] m, input int clocks_before);
        keys = m;
        repeat (clocks_before) @(negedge CLOCK);
        RESET_N = 1'b0;
        mon_en  = 1'b0;
        sb.delete();
        repeat (3) @(negedge CLOCK);
        RESET_N = 1'b1;
        base    = cyc;
        hist.delete();
        m_held  = 1'b0;
        m_digit = 12;
        mon_en  = 1'b1;
        check("reset_key_row", int'(KEY_ROW), 14);
        check("reset_digit_out", int'(DIGIT_OUT), 12);
        check("reset_pulses", int'({DIGIT_VALID, CLEAR_PULSE, ENTER_PULSE}), 0);
        check("reset_key_held", int'(KEY_HELD), 0);
    endtask

    // Monitor: row walk every cycle, and every pulse matched against the scoreboard.
    always @(negedge CLOCK) begin
        int         np;
        int         ri;
        int         kind;
        logic [3:0] exp_row;
        ev_t        e;
        if (mon_en) begin
            ri = ((cyc - base) / SCAN_DIV) % 4;
            exp_row = 4'hF;
            exp_row[ri] = 1'b0;
            check("key_row", int'(KEY_ROW), int'(exp_row));
            np = int'(DIGIT_VALID) + int'(CLEAR_PULSE) + int'(ENTER_PULSE);
            check("pulses_at_most_one", int'(np > 1), 0);
            if (np != 0) begin
                kind = DIGIT_VALID ? 0 : (CLEAR_PULSE ? 1 : 2);
                if (sb.size() == 0) begin
                    check("unexpected_pulse_kind", kind, -1);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind", kind, e.kind);
                    check("pulse_cycle", cyc, e.cyc);
                    check("digit_out_at_pulse", int'(DIGIT_OUT), e.digit);
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check("missing_pulse_kind", -1, e.kind);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        int          k1;
        int          k2;
        int          sel;
        int          len;
        int          done;

        apply_reset(16'h0, 2);
        do_scans(16'h0, 2);

        // Steady '5' press, then release.
        do_scans(16'h1 << K5, 6);
        do_scans(16'h0, 3);

        // Bouncing '8'.
        do_scans(16'h1 << K8, 2);
        do_scans(16'h0, 1);
        do_scans(16'h1 << K8, 3);
        do_scans(16'h0, 3);

        // Two keys together never start a press; then '*'.
        do_scans((16'h1 << K1) | (16'h1 << K9), 5);
        do_scans(16'h1 << KSTAR, 3);
        do_scans(16'h0, 3);

        // '#', then '0', then silent 'A'.
        do_scans(16'h1 << KHASH, 3);
        do_scans(16'h0, 3);
        do_scans(16'h1 << K0, 3);
        do_scans(16'h0, 3);
        do_scans(16'h1 << KA, 4);
        do_scans(16'h0, 3);

        // Reset during the second scan of a '3' press, key still held afterwards.
        do_scan(16'h1 << K3);
        apply_reset(16'h1 << K3, 7);
        do_scans(16'h1 << K3, 4);
        do_scans(16'h0, 3);

        // Randomised runs of single keys, silence and multi-key chords.
        done = 0;
        while (done < 90) begin
            sel = $urandom_range(0, 9);
            len = $urandom_range(1, 5);
            k1  = $urandom_range(0, 15);
            k2  = (k1 + $urandom_range(1, 15)) % 16;
            if (sel < 2) m = 16'h0;
            else if (sel == 2) m = (16'h1 << k1) | (16'h1 << k2);
            else m = 16'h1 << k1;
            do_scans(m, len);
            done += len;
        end

        do_scans(16'h0, 4);
        repeat (2) @(negedge CLOCK);
        check("final_key_held", int'(KEY_HELD), int'(m_held));
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_digit_entry.md
Name: keypad_digit_entry

Overview:
- Scans a 4x4 active-low matrix keypad, debounces key presses and emits one single-cycle event per press.
- Numeric keys (0-9) produce DIGIT_OUT plus a DIGIT_VALID pulse. These drive the barcode digit shift register's digit input and shift enable directly.
- '*' produces CLEAR_PULSE, which is inverted at the top level into the shift register's RESET_N. '#' produces ENTER_PULSE for the lookup/checkout logic.

Parameters:
- SCAN_DIV, 50000: clocks per row slot (1 ms at 50 MHz); minimum 4.
- DEBOUNCE_SCANS, 10: consecutive identical full-scan results required to accept a press or a release; minimum 1.

Ports:
- CLOCK  in  1  system clock (CLOCK_50).
- RESET_N  in  1  synchronous, active-low reset.
- KEY_COL  in  4  keypad columns; active-low, externally pulled up, asynchronous.
- KEY_ROW  out  4  row drive; active-low, exactly one bit low at any time.
- DIGIT_OUT  out  4  last accepted digit, 0-9; reset value 12.
- DIGIT_VALID  out  1  one-cycle pulse; DIGIT_OUT is valid in the same cycle.
- CLEAR_PULSE  out  1  one-cycle pulse on an accepted '*'.
- ENTER_PULSE  out  1  one-cycle pulse on an accepted '#'.
- KEY_HELD  out  1  high while in PRESSED or REL_DEB.

Behaviour:
- Reset (RESET_N low at a CLOCK edge):
  - KEY_ROW=4'b1110, DIGIT_OUT=12, all pulses 0, KEY_HELD=0.
  - Row index 0, divider 0, state IDLE, candidate=NONE, debounce count 0, synchroniser flops=4'b1111.
  - Reset mid-debounce or mid-press discards all progress; no pulse is emitted afterwards for that press.
- Synchronisation: KEY_COL passes through a 2-flop synchroniser; only the synchronised value is used.
- Scanning:
  - The divider counts 0..SCAN_DIV-1.
  - When divider==SCAN_DIV-1: sample the synchronised columns for the current row, advance the row (3 wraps to 0) and update KEY_ROW on the same edge.
  - Full scan = 4*SCAN_DIV clocks. The scan result is evaluated after the row-3 sample.
- Key map (row r, column c; column bit c low = pressed):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
- Scan result:
  - NONE if no column is low in any row.
  - KEY(code) if exactly one key over the whole scan.
  - MULTI if two or more keys.
  - MULTI is treated as NONE for release counting and never starts a press.
- FSM, evaluated once per full-scan result:
  - IDLE: a KEY result sets candidate=code, count=1 and goes to PRESS_DEB. If DEBOUNCE_SCANS==1, accept immediately instead.
  - PRESS_DEB:
    - Same KEY: count+1.
    - Different KEY: candidate reloaded, count=1.
    - NONE/MULTI: back to IDLE.
    - When count reaches DEBOUNCE_SCANS: accept and go to PRESSED.
  - PRESSED: any non-NONE/MULTI result holds the state; a NONE/MULTI result sets count=1 and goes to REL_DEB. Other keys pressed meanwhile are ignored; there is no auto-repeat.
  - REL_DEB:
    - NONE/MULTI: count+1.
    - Any KEY: back to PRESSED.
    - When count reaches DEBOUNCE_SCANS: go to IDLE.
- Accept action, registered:
  - Occurs in the clock after the row-3 sample of the accepting scan.
  - Digit key: DIGIT_OUT<=digit and DIGIT_VALID=1 for exactly one cycle.
  - '*': CLEAR_PULSE for one cycle.
  - '#': ENTER_PULSE for one cycle.
  - A-D: no pulse, but the FSM still goes to PRESSED.
  - At most one pulse output is high in any cycle.
- DIGIT_OUT holds its value between accepts, and also holds across '*'.
- Counter widths: sized for DEBOUNCE_SCANS and SCAN_DIV-1 with no overflow; the count saturates.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3; 16-clock scan):
- After reset: KEY_ROW=1110, then 1101, 1011, 0111 each 4 clocks, wrapping; DIGIT_OUT=12, all pulses 0.
- Hold '5' (col1 low while row1 driven) for 6 scans -> exactly one DIGIT_VALID with DIGIT_OUT=5, one clock after the third scan's row-3 sample. KEY_HELD=1 until 3 release scans complete; no second pulse.
- Bounce '8': present 2 scans, absent 1 scan, present 3 scans -> a single DIGIT_VALID, DIGIT_OUT=8, after the 3rd consecutive present scan.
- '1' and '9' held together for 5 scans -> no pulses, KEY_HELD=0. Then press '*' -> CLEAR_PULSE=1 for 1 cycle, DIGIT_OUT unchanged.
- Sequence '#', release, '0' -> ENTER_PULSE, then DIGIT_VALID with DIGIT_OUT=0. Pressing 'A' -> no pulse, KEY_HELD=1.
- Assert RESET_N low during scan 2 of a '3' press, release reset with '3' still held -> all outputs at reset values. A pulse occurs only after 3 full new scans, with DIGIT_OUT=3.
